// File: rtl/atm_terminal_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one ATM transaction core between N_TERM terminals, with per-account wrong-PIN lockout.
// Latency: gnt one cycle after req is seen in IDLE; rsp_valid TXN_CYCLES+2 cycles after (locked reject: 2).
// Backpressure: requests are held by terminals until gnt; one transaction in flight, others wait in req.
module atm_terminal_arbiter #(
    parameter int N_TERM     = 4,
    parameter int TXN_CYCLES = 4,
    parameter int MAX_FAIL   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_TERM-1:0]      req,
    input  logic [3*N_TERM-1:0]    req_op,
    input  logic [4*N_TERM-1:0]    req_acc,
    input  logic [16*N_TERM-1:0]   req_pin,
    input  logic [16*N_TERM-1:0]   req_new_pin,
    input  logic [32*N_TERM-1:0]   req_amount,
    input  logic [N_TERM-1:0]      req_lang,
    input  logic                   admin_unlock,
    input  logic [3:0]             admin_acc,
    output logic [N_TERM-1:0]      gnt,
    output logic [N_TERM-1:0]      rsp_valid,
    output logic [31:0]            rsp_balance,
    output logic                   rsp_success,
    output logic                   rsp_locked,
    output logic                   busy,
    output logic                   core_rst,
    output logic [2:0]             core_op,
    output logic [3:0]             core_acc,
    output logic [15:0]            core_pin,
    output logic [15:0]            core_new_pin,
    output logic [31:0]            core_amount,
    output logic                   core_lang,
    input  logic [31:0]            core_balance,
    input  logic                   core_success
);
    localparam int PW = (N_TERM > 1) ? $clog2(N_TERM) : 1;
    localparam int CW = $clog2(TXN_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, REJECT, RUN, RESP} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   term;
    logic [CW-1:0]   cnt;
    logic [1:0]      fail [16];

    logic            found;
    logic [PW-1:0]   pick;
    logic [3:0]      pick_acc;
    logic            pick_locked;
    logic [N_TERM-1:0] term_oh;
    logic            run_last;

    // First requesting terminal at or after rr_ptr, wrapping modulo N_TERM.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < N_TERM; i++) begin
            if (!found && req[(int'(rr_ptr) + i) % N_TERM]) begin
                found = 1'b1;
                pick  = PW'((int'(rr_ptr) + i) % N_TERM);
            end
        end
    end

    assign pick_acc    = req_acc[int'(pick)*4 +: 4];
    assign pick_locked = (fail[pick_acc] == 2'(MAX_FAIL));
    assign term_oh     = {{(N_TERM-1){1'b0}}, 1'b1} << term;
    assign run_last    = (cnt == CW'(TXN_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = pick_locked ? REJECT : LAUNCH;
            LAUNCH:  state_nxt = RUN;
            RUN:     if (run_last) state_nxt = RESP;
            REJECT:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign gnt       = (state == LAUNCH || state == REJECT) ? term_oh : '0;
    assign rsp_valid = (state == RESP) ? term_oh : '0;
    assign busy      = (state != IDLE);
    // Core is held in restart during our own reset so an aborted run cannot continue.
    assign core_rst  = !rst && (state != LAUNCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            term         <= '0;
            cnt          <= '0;
            core_op      <= '0;
            core_acc     <= '0;
            core_pin     <= '0;
            core_new_pin <= '0;
            core_amount  <= '0;
            core_lang    <= 1'b0;
            rsp_balance  <= '0;
            rsp_success  <= 1'b0;
            rsp_locked   <= 1'b0;
            for (int a = 0; a < 16; a++) fail[a] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (found) begin
                        term         <= pick;
                        rr_ptr       <= (int'(pick) == N_TERM - 1) ? '0 : pick + 1'b1;
                        core_op      <= req_op[int'(pick)*3 +: 3];
                        core_acc     <= pick_acc;
                        core_pin     <= req_pin[int'(pick)*16 +: 16];
                        core_new_pin <= req_new_pin[int'(pick)*16 +: 16];
                        core_amount  <= req_amount[int'(pick)*32 +: 32];
                        core_lang    <= req_lang[pick];
                    end
                end
                LAUNCH: cnt <= '0;
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (run_last) begin
                        rsp_balance <= core_balance;
                        rsp_success <= core_success;
                        rsp_locked  <= 1'b0;
                    end
                end
                REJECT: begin
                    rsp_balance <= '0;
                    rsp_success <= 1'b0;
                    rsp_locked  <= 1'b1;
                end
                RESP: begin
                    if (rsp_success)
                        fail[core_acc] <= '0;
                    else if (fail[core_acc] != 2'(MAX_FAIL))
                        fail[core_acc] <= fail[core_acc] + 2'd1;
                end
                default: ;
            endcase
            // Placed last so an unlock overrides a same-edge fail update.
            if (admin_unlock) fail[admin_acc] <= '0;
        end
    end
endmodule

// File: tb/tb_atm_terminal_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for atm_terminal_arbiter with a behavioural transaction core attached.
module tb_atm_terminal_arbiter;
    localparam int N = 4, TXN = 4, MF = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [N-1:0] req;
    logic [3*N-1:0] req_op;
    logic [4*N-1:0] req_acc;
    logic [16*N-1:0] req_pin, req_new_pin;
    logic [32*N-1:0] req_amount;
    logic [N-1:0] req_lang;
    logic admin_unlock;
    logic [3:0] admin_acc;
    logic [N-1:0] gnt, rsp_valid;
    logic [31:0] rsp_balance;
    logic rsp_success, rsp_locked, busy, core_rst;
    logic [2:0] core_op;
    logic [3:0] core_acc;
    logic [15:0] core_pin, core_new_pin;
    logic [31:0] core_amount;
    logic core_lang;
    logic [31:0] core_balance;
    logic core_success;

    atm_terminal_arbiter #(.N_TERM(N), .TXN_CYCLES(TXN), .MAX_FAIL(MF)) dut (
        .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_acc(req_acc),
        .req_pin(req_pin), .req_new_pin(req_new_pin), .req_amount(req_amount),
        .req_lang(req_lang), .admin_unlock(admin_unlock), .admin_acc(admin_acc),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_balance(rsp_balance),
        .rsp_success(rsp_success), .rsp_locked(rsp_locked), .busy(busy),
        .core_rst(core_rst), .core_op(core_op), .core_acc(core_acc),
        .core_pin(core_pin), .core_new_pin(core_new_pin), .core_amount(core_amount),
        .core_lang(core_lang), .core_balance(core_balance), .core_success(core_success)
    );

    typedef struct packed {
        logic [31:0] t;
        logic [31:0] bal;
        logic        succ;
        logic        lk;
    } exp_t;

    exp_t sb[$];
    int total = 0, bad = 0;
    int cyc = 0;
    int core_lo = 0;
    int core_cyc = 0;
    logic [31:0] r_bal [16], c_bal [16];
    logic [15:0] r_pin [16], c_pin [16];
    int r_fail [16];

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: results are only meaningful two run cycles after a restart.
    always @(negedge clk) begin
        if (!core_rst) core_cyc <= 0;
        else if (core_cyc < 15) core_cyc <= core_cyc + 1;
    end

    always_comb begin
        core_balance = 32'hDEAD_BEEF;
        core_success = 1'b0;
        if (core_cyc >= 2) begin
            core_balance = c_bal[core_acc];
            core_success = (core_pin == c_pin[core_acc]);
            case (core_op)
                3'd4: begin
                    core_success = core_success && (core_amount <= c_bal[core_acc]);
                    if (core_success) core_balance = c_bal[core_acc] - core_amount;
                end
                3'd5: if (core_success) core_balance = c_bal[core_acc] + core_amount;
                3'd3, 3'd6: ;
                default: core_success = 1'b0;
            endcase
        end
    end

    // Monitor: grant one-hotness, scoreboard pop, and core commit on success.
    always @(negedge clk) begin
        exp_t e;
        logic [N-1:0] oh;
        if (!rst && !core_rst) core_lo++;
        if (!rst && gnt != '0) begin
            total++;
            if (!$onehot(gnt)) begin
                bad++;
                $display("FAIL gnt_onehot: gnt=%b required one-hot", gnt);
            end
        end
        if (!rst && rsp_valid != '0) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_rsp: rsp_valid=%b required no response", rsp_valid);
            end else begin
                e = sb.pop_front();
                oh = 4'b0001 << e.t;
                total++;
                if (rsp_valid !== oh) begin bad++; $display("FAIL rsp_term: got=%b want=%b", rsp_valid, oh); end
                total++;
                if (rsp_balance !== e.bal) begin bad++; $display("FAIL rsp_balance: got=%0d want=%0d", rsp_balance, e.bal); end
                total++;
                if (rsp_success !== e.succ) begin bad++; $display("FAIL rsp_success: got=%b want=%b", rsp_success, e.succ); end
                total++;
                if (rsp_locked !== e.lk) begin bad++; $display("FAIL rsp_locked: got=%b want=%b", rsp_locked, e.lk); end
            end
            if (rsp_success === 1'b1) begin
                if (core_op == 3'd4 || core_op == 3'd5) c_bal[core_acc] = core_balance;
                if (core_op == 3'd6) c_pin[core_acc] = core_new_pin;
            end
        end
    end

    task automatic drive(input int t, input int op, input int acc, input logic [15:0] pin,
                         input logic [15:0] npin, input logic [31:0] amt);
        req_op[t*3 +: 3]       = 3'(op);
        req_acc[t*4 +: 4]      = 4'(acc);
        req_pin[t*16 +: 16]    = pin;
        req_new_pin[t*16 +: 16] = npin;
        req_amount[t*32 +: 32] = amt;
        req_lang[t]            = 1'(t);
        req[t]                 = 1'b1;
    endtask

    task automatic predict(input int t, input int op, input int acc, input logic [15:0] pin,
                           input logic [15:0] npin, input logic [31:0] amt);
        exp_t e;
        logic ok;
        logic [31:0] b;
        e.t = 32'(t);
        if (r_fail[acc] == MF) begin
            e.bal = 0; e.succ = 0; e.lk = 1;
        end else begin
            b = r_bal[acc];
            ok = (pin == r_pin[acc]);
            e.lk = 0;
            e.bal = b;
            if (op == 4) ok = ok && (amt <= b);
            if (op < 3 || op > 6) ok = 0;
            if (ok && op == 4) e.bal = b - amt;
            if (ok && op == 5) e.bal = b + amt;
            e.succ = ok;
            if (ok) begin
                r_bal[acc] = e.bal;
                if (op == 6) r_pin[acc] = npin;
                r_fail[acc] = 0;
            end else if (r_fail[acc] < MF) begin
                r_fail[acc]++;
            end
        end
        sb.push_back(e);
    endtask

    task automatic wait_gnt(input int t, output int c);
        c = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (gnt[t]) begin c = cyc; break; end
        end
    endtask

    task automatic wait_rsp(input int t, output int c);
        c = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rsp_valid[t]) begin c = cyc; break; end
        end
    endtask

    // One isolated transaction; returns grant and response latency from the IDLE cycle.
    task automatic run_one(input int t, input int op, input int acc, input logic [15:0] pin,
                           input logic [15:0] npin, input logic [31:0] amt,
                           output int gl, output int rl);
        int c0, cg, cr;
        @(negedge clk);
        drive(t, op, acc, pin, npin, amt);
        predict(t, op, acc, pin, npin, amt);
        c0 = cyc;
        wait_gnt(t, cg);
        req[t] = 1'b0;
        wait_rsp(t, cr);
        gl = (cg < 0) ? -1 : cg - c0;
        rl = (cr < 0) ? -1 : cr - c0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        drive(0, 5, 1, 16'd1234, 16'd0, 32'd1000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (gnt !== '0) begin bad++; $display("FAIL reset_gnt: got=%b want=0", gnt); end
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL reset_rsp_valid: got=%b want=0", rsp_valid); end
        total++; if ({rsp_balance, rsp_success, rsp_locked} !== 34'd0) begin bad++; $display("FAIL reset_rsp_data: got=%h want=0", {rsp_balance, rsp_success, rsp_locked}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b want=0", busy); end
        total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL reset_core_rst: got=%b want=0", core_rst); end
        total++;
        if ({core_op, core_acc, core_pin, core_new_pin, core_amount, core_lang} !== 72'd0) begin
            bad++; $display("FAIL reset_operands: got=%h want=0",
                {core_op, core_acc, core_pin, core_new_pin, core_amount, core_lang});
        end
        req = '0;
        rst = 1'b0;
        @(negedge clk);
        total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL idle_core_rst: got=%b want=1", core_rst); end
    endtask

    task automatic test_fairness;
        int prev, c, k;
        @(negedge clk);
        drive(0, 5, 4, 16'd1004, 16'd0, 32'd10);
        drive(1, 4, 5, 16'd1005, 16'd0, 32'd100);
        drive(2, 3, 6, 16'd1006, 16'd0, 32'd0);
        drive(3, 6, 7, 16'd1007, 16'd777, 32'd0);
        predict(0, 5, 4, 16'd1004, 16'd0, 32'd10);
        predict(1, 4, 5, 16'd1005, 16'd0, 32'd100);
        predict(2, 3, 6, 16'd1006, 16'd0, 32'd0);
        predict(3, 6, 7, 16'd1007, 16'd777, 32'd0);
        predict(0, 5, 4, 16'd1004, 16'd0, 32'd10);
        prev = 0;
        for (int g = 0; g < 5; g++) begin
            c = -1; k = -1;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (gnt != '0) begin
                    c = cyc;
                    for (int j = 0; j < N; j++) if (gnt[j]) k = j;
                    break;
                end
            end
            total++;
            if (k != g % N) begin bad++; $display("FAIL rr_order[%0d]: got=%0d want=%0d", g, k, g % N); end
            if (g > 0) begin
                total++;
                if (c - prev != TXN + 3) begin bad++; $display("FAIL rr_spacing[%0d]: got=%0d want=%0d", g, c - prev, TXN + 3); end
            end
            prev = c;
        end
        req = '0;
        wait_rsp(0, c);
        total++; if (c < 0) begin bad++; $display("FAIL rr_drain: got=timeout want=rsp"); end
    endtask

    task automatic test_single;
        int gl, rl, lo0;
        lo0 = core_lo;
        run_one(0, 5, 1, 16'd1234, 16'd0, 32'd1000, gl, rl);
        total++; if (gl != 1) begin bad++; $display("FAIL single_gnt_lat: got=%0d want=1", gl); end
        total++; if (rl != TXN + 2) begin bad++; $display("FAIL single_rsp_lat: got=%0d want=%0d", rl, TXN + 2); end
        total++; if (rsp_balance !== 32'd6100) begin bad++; $display("FAIL single_balance: got=%0d want=6100", rsp_balance); end
        total++; if (core_lo - lo0 != 1) begin bad++; $display("FAIL single_core_restart: got=%0d want=1", core_lo - lo0); end
    endtask

    task automatic test_lockout;
        int gl, rl, lo0;
        for (int n = 0; n < MF; n++) begin
            run_one(2, 3, 2, 16'd9999, 16'd0, 32'd0, gl, rl);
            total++; if (rl != TXN + 2) begin bad++; $display("FAIL lock_fail_lat[%0d]: got=%0d want=%0d", n, rl, TXN + 2); end
        end
        lo0 = core_lo;
        run_one(2, 3, 2, 16'd9999, 16'd0, 32'd0, gl, rl);
        total++; if (gl != 1) begin bad++; $display("FAIL lock_gnt_lat: got=%0d want=1", gl); end
        total++; if (rl != 2) begin bad++; $display("FAIL lock_rsp_lat: got=%0d want=2", rl); end
        total++; if (core_lo != lo0) begin bad++; $display("FAIL lock_core_restart: got=%0d want=0", core_lo - lo0); end
    endtask

    task automatic test_unlock;
        int gl, rl, cg, cr;
        @(negedge clk);
        admin_acc = 4'd2; admin_unlock = 1'b1; r_fail[2] = 0;
        @(negedge clk);
        admin_unlock = 1'b0;
        run_one(1, 3, 2, 16'd2345, 16'd0, 32'd0, gl, rl);
        total++; if (rl != TXN + 2) begin bad++; $display("FAIL unlock_rsp_lat: got=%0d want=%0d", rl, TXN + 2); end
        run_one(2, 3, 2, 16'd1, 16'd0, 32'd0, gl, rl);
        run_one(2, 3, 2, 16'd1, 16'd0, 32'd0, gl, rl);
        // Third failure would lock; the unlock on the same RESP edge must win.
        @(negedge clk);
        drive(2, 3, 2, 16'd1, 16'd0, 32'd0);
        predict(2, 3, 2, 16'd1, 16'd0, 32'd0);
        wait_gnt(2, cg);
        req[2] = 1'b0;
        wait_rsp(2, cr);
        admin_acc = 4'd2; admin_unlock = 1'b1; r_fail[2] = 0;
        @(negedge clk);
        admin_unlock = 1'b0;
        total++; if (cr < 0) begin bad++; $display("FAIL collide_rsp: got=timeout want=rsp"); end
        run_one(3, 3, 2, 16'd1, 16'd0, 32'd0, gl, rl);
        total++; if (rl != TXN + 2) begin bad++; $display("FAIL collide_not_locked_lat: got=%0d want=%0d", rl, TXN + 2); end
    endtask

    task automatic test_abort;
        int cg, seen, k, cr;
        @(negedge clk);
        drive(1, 5, 3, 16'd1003, 16'd0, 32'd50);
        wait_gnt(1, cg);
        req[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 16; a++) r_fail[a] = 0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got=%b want=0", busy); end
        seen = 0;
        for (int i = 0; i < TXN + 4; i++) begin
            @(negedge clk);
            if (rsp_valid != '0) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL abort_rsp: got=%0d want=0", seen); end
        // rr_ptr back at 0 means terminal 1 is chosen ahead of terminal 3.
        drive(3, 3, 8, 16'd1008, 16'd0, 32'd0);
        drive(1, 5, 3, 16'd1003, 16'd0, 32'd50);
        predict(1, 5, 3, 16'd1003, 16'd0, 32'd50);
        predict(3, 3, 8, 16'd1008, 16'd0, 32'd0);
        for (int g = 0; g < 2; g++) begin
            k = -1;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (gnt != '0) begin
                    for (int j = 0; j < N; j++) if (gnt[j]) k = j;
                    break;
                end
            end
            total++;
            if (k != (g == 0 ? 1 : 3)) begin bad++; $display("FAIL abort_rr[%0d]: got=%0d want=%0d", g, k, g == 0 ? 1 : 3); end
            if (k >= 0) req[k] = 1'b0;
        end
        wait_rsp(3, cr);
        total++; if (cr < 0) begin bad++; $display("FAIL abort_reissue: got=timeout want=rsp"); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req = '0; req_op = '0; req_acc = '0; req_pin = '0; req_new_pin = '0;
        req_amount = '0; req_lang = '0; admin_unlock = 1'b0; admin_acc = '0; rst = 1'b1;
        for (int a = 0; a < 16; a++) begin
            r_bal[a] = 32'(5000 + 100 * a);
            r_pin[a] = 16'(1000 + a);
            r_fail[a] = 0;
        end
        r_pin[1] = 16'd1234;
        r_pin[2] = 16'd2345;
        for (int a = 0; a < 16; a++) begin
            c_bal[a] = r_bal[a];
            c_pin[a] = r_pin[a];
        end
        test_reset;
        test_fairness;
        test_single;
        test_lockout;
        test_unlock;
        test_abort;
        repeat (4) @(negedge clk);
        total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_drain: got=%0d want=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
